seq_gen: RTL



---
 rtl/seq_gen_if.sv | 34 +++
 rtl/seq_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_gen_if.sv
//------------------------------------------------------------------------------
// seq_gen_if : control and serial-output bundle for the seq_gen transmitter.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, len, reps, gap,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, reps, gap,
    output dout, dout_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/seq_gen.sv
//------------------------------------------------------------------------------
// seq_gen : serial bit-sequence generator, MSB-first frames with repeat and gap.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] c_pat_w   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [PAT_W-1:0] c_pat_one = PAT_W'(1);

  state_t           r_state, w_state_nx;
  logic [PAT_W-1:0] r_pat, w_pat_nx;
  logic [LEN_W-1:0] r_last, w_last_nx;
  logic [LEN_W-1:0] r_idx, w_idx_nx;
  logic [CNT_W-1:0] r_frames, w_frames_nx;
  logic [CNT_W-1:0] r_gap, w_gap_nx;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nx;
  logic             r_dout, w_dout_nx;
  logic             r_valid, w_valid_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;

  logic [LEN_W-1:0] w_len_eff, w_in_last, w_idx_dec;
  logic             w_in_bit, w_first_bit, w_next_bit;

  // Out-of-range lengths (0 or wider than the pattern) send the full register.
  assign w_len_eff   = (bus.len == '0 || bus.len > c_pat_w) ? c_pat_w : bus.len;
  assign w_in_last   = w_len_eff - c_len_one;
  assign w_idx_dec   = r_idx - c_len_one;
  assign w_in_bit    = |(bus.pattern & (c_pat_one << w_in_last));
  assign w_first_bit = |(r_pat & (c_pat_one << r_last));
  assign w_next_bit  = |(r_pat & (c_pat_one << w_idx_dec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_last    <= '0;
      r_idx     <= '0;
      r_frames  <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_dout    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pat     <= w_pat_nx;
      r_last    <= w_last_nx;
      r_idx     <= w_idx_nx;
      r_frames  <= w_frames_nx;
      r_gap     <= w_gap_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_dout    <= w_dout_nx;
      r_valid   <= w_valid_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
    end
  end

  // Next-state logic computes the value each output takes in the coming cycle.
  always_comb begin
    w_state_nx   = r_state;
    w_pat_nx     = r_pat;
    w_last_nx    = r_last;
    w_idx_nx     = r_idx;
    w_frames_nx  = r_frames;
    w_gap_nx     = r_gap;
    w_gap_cnt_nx = r_gap_cnt;
    w_dout_nx    = 1'b0;
    w_valid_nx   = 1'b0;
    w_busy_nx    = 1'b0;
    w_done_nx    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx  = SHIFT;
          w_pat_nx    = bus.pattern;
          w_last_nx   = w_in_last;
          w_idx_nx    = w_in_last;
          w_frames_nx = bus.reps;
          w_gap_nx    = bus.gap;
          w_dout_nx   = w_in_bit;
          w_valid_nx  = 1'b1;
          w_busy_nx   = 1'b1;
        end
      end
      SHIFT: begin
        w_busy_nx = 1'b1;
        if (r_idx != '0) begin
          w_idx_nx   = w_idx_dec;
          w_dout_nx  = w_next_bit;
          w_valid_nx = 1'b1;
        end else if (r_frames != '0) begin
          w_frames_nx = r_frames - c_cnt_one;
          if (r_gap != '0) begin
            w_state_nx   = GAP;
            w_gap_cnt_nx = r_gap;
          end else begin
            w_idx_nx   = r_last;
            w_dout_nx  = w_first_bit;
            w_valid_nx = 1'b1;
          end
        end else begin
          w_state_nx = DONE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end
      end
      GAP: begin
        w_busy_nx = 1'b1;
        if (r_gap_cnt == c_cnt_one) begin
          w_state_nx = SHIFT;
          w_idx_nx   = r_last;
          w_dout_nx  = w_first_bit;
          w_valid_nx = 1'b1;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - c_cnt_one;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    if (r_state != IDLE && bus.abort) begin
      w_state_nx = IDLE;
      w_dout_nx  = 1'b0;
      w_valid_nx = 1'b0;
      w_busy_nx  = 1'b0;
      w_done_nx  = 1'b0;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire
